// File: rtl/parking_sensor_conditioner_if.sv
// rtl/parking_sensor_conditioner_if.sv - lane sensor inputs and conditioned gate/occupancy outputs
interface parking_sensor_conditioner_if #(
  parameter int CNT_W = 4
);
  logic             raw_entrance;
  logic             raw_exit;
  logic             raw_leave;
  logic             clear_err;
  logic             sensor_entrance;
  logic             sensor_exit;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             car_in_pulse;
  logic             car_out_pulse;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output raw_entrance, raw_exit, raw_leave, clear_err,
    input  sensor_entrance, sensor_exit, occupancy, full, empty,
           car_in_pulse, car_out_pulse, overflow_err, underflow_err
  );

  modport slave (
    input  raw_entrance, raw_exit, raw_leave, clear_err,
    output sensor_entrance, sensor_exit, occupancy, full, empty,
           car_in_pulse, car_out_pulse, overflow_err, underflow_err
  );
endinterface

// File: rtl/parking_sensor_conditioner.sv
// rtl/parking_sensor_conditioner.sv - sync/debounce of three lane sensors plus lot occupancy
// Channel index: 0 = entrance, 1 = exit (gate pass), 2 = leave.
module parking_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CAPACITY        = 8,
  parameter int CNT_W           = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  parking_sensor_conditioner_if.slave   bus
);
  localparam int            DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    stable;
  logic [2:0]    rise;
  logic [DW-1:0] cnt [3];

  logic [CNT_W-1:0] occupancy;
  logic             overflow_err;
  logic             underflow_err;
  logic             full_w;
  logic             empty_w;
  logic             in_only;
  logic             out_only;

  assign raw = {bus.raw_leave, bus.raw_exit, bus.raw_entrance};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      rise   <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        // rise registers alongside stable so the pulse shares the cycle stable first reads 1
        rise[i] <= s2[i] && !stable[i] && (cnt[i] == CNT_LAST);
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  assign full_w   = (occupancy == CNT_W'(CAPACITY));
  assign empty_w  = (occupancy == '0);
  assign in_only  = rise[1] && !rise[2];
  assign out_only = rise[2] && !rise[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy     <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (in_only && !full_w) begin
        occupancy <= occupancy + CNT_W'(1);
      end else if (out_only && !empty_w) begin
        occupancy <= occupancy - CNT_W'(1);
      end
      // a new error outranks a coincident clear
      overflow_err  <= (in_only && full_w)   || (overflow_err  && !bus.clear_err);
      underflow_err <= (out_only && empty_w) || (underflow_err && !bus.clear_err);
    end
  end

  assign bus.sensor_entrance = stable[0] && !full_w;
  assign bus.sensor_exit     = stable[1];
  assign bus.occupancy       = occupancy;
  assign bus.full            = full_w;
  assign bus.empty           = empty_w;
  assign bus.car_in_pulse    = rise[1];
  assign bus.car_out_pulse   = rise[2];
  assign bus.overflow_err    = overflow_err;
  assign bus.underflow_err   = underflow_err;
endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// tb/tb_parking_sensor_conditioner.sv - directed and randomized checks against a window-based reference model
module tb_parking_sensor_conditioner;
  localparam int DEB = 4;
  localparam int CAP = 8;
  localparam int CW  = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  parking_sensor_conditioner_if #(.CNT_W(CW)) bus ();

  parking_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CAPACITY       (CAP),
    .CNT_W          (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  if (CAP >= (1 << CW)) begin : g_bad_param
    initial $fatal(1, "FAIL param: CAPACITY %0d does not fit CNT_W %0d", CAP, CW);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a channel accepts a new level once its synchronised input
  // (raw delayed two edges) has differed from the accepted level over the last
  // DEB edges, and at least DEB edges have passed since its previous acceptance.
  int k = 100;
  bit hist [3][64];
  bit st_m [3];
  bit pm   [3];
  int last_acc [3];
  int occ_m;
  bit ovf_m, unf_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      st_m[c]     = 1'b0;
      pm[c]       = 1'b0;
      last_acc[c] = k - DEB;
      for (int j = 0; j < 64; j++) hist[c][j] = 1'b0;
    end
    occ_m = 0;
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic model_edge();
    bit raw [3];
    bit acc;
    raw[0] = bus.raw_entrance;
    raw[1] = bus.raw_exit;
    raw[2] = bus.raw_leave;
    k++;
    if (bus.clear_err) begin
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end
    if (pm[1] && !pm[2]) begin
      if (occ_m == CAP) ovf_m = 1'b1;
      else occ_m++;
    end else if (pm[2] && !pm[1]) begin
      if (occ_m == 0) unf_m = 1'b1;
      else occ_m--;
    end
    for (int c = 0; c < 3; c++) begin
      hist[c][k & 63] = raw[c];
      acc = ((k - last_acc[c]) >= DEB);
      for (int j = 0; j < DEB; j++)
        if (hist[c][(k - 2 - j) & 63] == st_m[c]) acc = 1'b0;
      pm[c] = 1'b0;
      if (acc) begin
        st_m[c]     = ~st_m[c];
        last_acc[c] = k;
        pm[c]       = st_m[c];
      end
    end
  endtask

  task automatic compare_all();
    check_eq("sensor_entrance", 32'(bus.sensor_entrance), 32'(st_m[0] && (occ_m != CAP)));
    check_eq("sensor_exit",     32'(bus.sensor_exit),     32'(st_m[1]));
    check_eq("occupancy",       32'(bus.occupancy),       32'(occ_m));
    check_eq("full",            32'(bus.full),            32'(occ_m == CAP));
    check_eq("empty",           32'(bus.empty),           32'(occ_m == 0));
    check_eq("car_in_pulse",    32'(bus.car_in_pulse),    32'(pm[1]));
    check_eq("car_out_pulse",   32'(bus.car_out_pulse),   32'(pm[2]));
    check_eq("overflow_err",    32'(bus.overflow_err),    32'(ovf_m));
    check_eq("underflow_err",   32'(bus.underflow_err),   32'(unf_m));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic set_raw(input int c, input logic v);
    case (c)
      0:       bus.raw_entrance = v;
      1:       bus.raw_exit     = v;
      default: bus.raw_leave    = v;
    endcase
  endtask

  task automatic pulse_chan(input int c, input int hi, input int lo);
    set_raw(c, 1'b1);
    repeat (hi) step();
    set_raw(c, 1'b0);
    repeat (lo) step();
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.raw_entrance = 1'b0;
    bus.raw_exit     = 1'b0;
    bus.raw_leave    = 1'b0;
    bus.clear_err    = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  initial begin
    int hold [3];
    bus.raw_entrance = 1'b0;
    bus.raw_exit     = 1'b0;
    bus.raw_leave    = 1'b0;
    bus.clear_err    = 1'b0;
    model_reset();
    #1;
    do_reset();

    // debounce latency on the entrance channel
    bus.raw_entrance = 1'b1;
    repeat (5) step();
    check_eq("lat_edge5", 32'(bus.sensor_entrance), 32'd0);
    step();
    check_eq("lat_edge6", 32'(bus.sensor_entrance), 32'd1);

    // 3-cycle glitch on exit must be rejected
    pulse_chan(1, 3, 10);
    check_eq("glitch_exit", 32'(bus.sensor_exit), 32'd0);
    check_eq("glitch_occ",  32'(bus.occupancy),   32'd0);

    // underflow from empty, then clear
    pulse_chan(2, DEB + 1, DEB + 4);
    check_eq("unf_occ",  32'(bus.occupancy),     32'd0);
    check_eq("unf_flag", 32'(bus.underflow_err), 32'd1);
    bus.clear_err = 1'b1;
    step();
    bus.clear_err = 1'b0;
    check_eq("unf_clear", 32'(bus.underflow_err), 32'd0);

    // fill the lot, then overflow
    repeat (CAP) pulse_chan(1, DEB + 1, DEB + 2);
    repeat (4) step();
    check_eq("fill_occ",  32'(bus.occupancy),       32'(CAP));
    check_eq("fill_full", 32'(bus.full),            32'd1);
    check_eq("fill_mask", 32'(bus.sensor_entrance), 32'd0);
    pulse_chan(1, DEB + 1, DEB + 4);
    check_eq("ovf_occ",  32'(bus.occupancy),    32'(CAP));
    check_eq("ovf_flag", 32'(bus.overflow_err), 32'd1);
    bus.clear_err = 1'b1;
    step();
    bus.clear_err = 1'b0;

    // simultaneous in/out while full
    bus.raw_exit  = 1'b1;
    bus.raw_leave = 1'b1;
    repeat (DEB + 1) step();
    bus.raw_exit  = 1'b0;
    bus.raw_leave = 1'b0;
    repeat (DEB + 4) step();
    check_eq("sim_occ", 32'(bus.occupancy),     32'(CAP));
    check_eq("sim_ovf", 32'(bus.overflow_err),  32'd0);
    check_eq("sim_unf", 32'(bus.underflow_err), 32'd0);
    pulse_chan(2, DEB + 1, DEB + 4);
    check_eq("leave_occ",   32'(bus.occupancy),       32'(CAP - 1));
    check_eq("leave_unmask", 32'(bus.sensor_entrance), 32'd1);

    // reset in the middle of a debounce at occupancy 5
    repeat (2) pulse_chan(2, DEB + 1, DEB + 4);
    check_eq("pre_rst_occ", 32'(bus.occupancy), 32'd5);
    bus.raw_exit = 1'b1;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check_eq("rst_occ",   32'(bus.occupancy),       32'd0);
    check_eq("rst_empty", 32'(bus.empty),           32'd1);
    check_eq("rst_ent",   32'(bus.sensor_entrance), 32'd0);
    check_eq("rst_exit",  32'(bus.sensor_exit),     32'd0);
    do_reset();
    repeat (20) begin
      step();
      check_eq("post_rst_no_pulse", 32'(bus.car_in_pulse), 32'd0);
    end

    // randomized traffic with occasional clear and reset
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          case (c)
            0:       bus.raw_entrance = ~bus.raw_entrance;
            1:       bus.raw_exit     = ~bus.raw_exit;
            default: bus.raw_leave    = ~bus.raw_leave;
          endcase
          hold[c] = int'($urandom_range(1, 10));
        end
        hold[c]--;
      end
      bus.clear_err = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 699) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        step();
        reset_n = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/parking_sensor_conditioner.md
# parking_sensor_conditioner

Front-end stage for the car-park gate controller. It synchronises and debounces the three raw lane sensors and drives the clean `sensor_entrance` / `sensor_exit` levels that the gate FSM consumes. It also keeps the lot occupancy count. When the lot is full it masks the entrance request so that the gate FSM never leaves IDLE.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a new level must hold before it is accepted; legal range ≥1.
- CAPACITY, 8: number of parking spaces.
- CNT_W, 4: occupancy width; 2^CNT_W > CAPACITY is required.

Ports:
- clk  in  1  system clock; all flops rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- raw_entrance  in  1  asynchronous approach sensor, high = car present.
- raw_exit  in  1  asynchronous gate-pass sensor; a rising edge means a car entered the lot.
- raw_leave  in  1  asynchronous outgoing-lane sensor; a rising edge means a car left the lot.
- clear_err  in  1  synchronous clear of the sticky error flags.
- sensor_entrance  out  1  clean entrance level AND NOT full; goes to the gate FSM.
- sensor_exit  out  1  clean gate-pass level; goes to the gate FSM.
- occupancy  out  CNT_W  cars currently in the lot.
- full  out  1  high when occupancy == CAPACITY.
- empty  out  1  high when occupancy == 0.
- car_in_pulse  out  1  one-cycle pulse on each accepted gate-pass rising edge.
- car_out_pulse  out  1  one-cycle pulse on each accepted leave rising edge.
- overflow_err  out  1  sticky; an increment was attempted while full.
- underflow_err  out  1  sticky; a decrement was attempted while empty.

## Operation
- **Per channel (entrance, exit, leave):** identical two-flop synchroniser (s1, s2), then a debouncer with its own counter `cnt` and a `stable` register.
- **Debouncer rules, evaluated each edge:**
  - If s2 == stable: `cnt` <= 0.
  - If s2 != stable and `cnt` < DEBOUNCE_CYCLES-1: `cnt` <= `cnt` + 1.
  - If s2 != stable and `cnt` == DEBOUNCE_CYCLES-1: `stable` <= s2 and `cnt` <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches `stable`.
- **Edge pulses:**
  - Registered rise pulse = the debouncer accepting a 0→1 transition. It is high for exactly the one cycle in which `stable` first reads 1.
  - Falling edges produce no pulse.
  - car_in_pulse is the exit-channel rise pulse; car_out_pulse is the leave-channel rise pulse.
- **Occupancy update, on the edge after a pulse:**
  - in only, not full: +1.
  - in only, full: no change; overflow_err <= 1.
  - out only, not empty: −1.
  - out only, empty: no change; underflow_err <= 1.
  - in and out in the same cycle: no change and no error, even when full or empty.
- **Error flags:** clear_err clears both flags. If clear_err coincides with a new error, the error wins and the flag is set.
- **Derived outputs:** full, empty and sensor_entrance are combinational from registers. sensor_exit = exit `stable`, unmasked.
- **Illegal parameter (CAPACITY ≥ 2^CNT_W):** not supported; the bench checks the legal relation at elaboration.

## Timing
- **Reset values:** all sync flops, `stable` registers, counters, occupancy, pulses and error flags are 0.
  - Outputs during reset: sensor_entrance=0, sensor_exit=0, occupancy=0, full=0 (full=1 only if CAPACITY=0, which is unsupported), empty=1, car_in_pulse=0, car_out_pulse=0, overflow_err=0, underflow_err=0.
- **Debounce latency:** a raw level change held steady before edge 1 appears on `stable` (and so on sensor_entrance / sensor_exit) after edge 2+DEBOUNCE_CYCLES. With the default, that is edge 6.
- **Pulse and occupancy latency:** the pulse is high in the cycle following edge 2+DEBOUNCE_CYCLES. Occupancy, full and empty change after edge 3+DEBOUNCE_CYCLES.
- **Masking:** sensor_entrance drops in the same cycle full rises. It returns as soon as occupancy < CAPACITY, provided the clean entrance level is still high.
- **Raw input held high through reset release:** it is debounced normally and yields a pulse. This is by design; no start-up suppression.
- **Reset asserted mid-operation:** all state clears immediately (asynchronous). Any debounce in progress is discarded.
- **Minimum pulse spacing:** back-to-back cars on one channel need at least 2·DEBOUNCE_CYCLES cycles between raw rising edges: high DEBOUNCE_CYCLES, then low DEBOUNCE_CYCLES.

## Test plan
1. **Debounce latency:** reset, raw_entrance 0→1 held → sensor_entrance=1 exactly after edge 6 (DEBOUNCE_CYCLES=4).
2. **Glitch rejection:** raw_exit high 3 cycles then low → sensor_exit stays 0, no car_in_pulse, occupancy stays 0.
3. **Fill and overflow:**
   - 8 clean raw_exit pulses → occupancy=8, full=1, sensor_entrance=0 while raw_entrance held high.
   - 9th pulse → occupancy stays 8, overflow_err=1.
4. **Underflow and clear:** from empty, one raw_leave pulse → occupancy=0, underflow_err=1; clear_err for 1 cycle → underflow_err=0.
5. **Simultaneous events:**
   - At occupancy=8, raw_exit and raw_leave rise together → occupancy stays 8, no error flags.
   - Then a lone leave → 7, sensor_entrance reasserts.
6. **Reset mid-operation:** at occupancy=5 with a debounce half complete, pulse reset_n low → all outputs return to their reset values asynchronously, and no pulse appears after release.
